// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_rx_fifo
// Purpose  : Receive-side byte buffer behind the UART receiver. Captures each
//            completed byte on the rising edge of rx_ready, acknowledges it
//            with a one-cycle clear pulse, and stores it in a first-word-
//            fall-through FIFO with a valid/ready output stream. Bytes that
//            arrive while the FIFO is full are dropped, flagged and counted.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_ready_i,
  output logic                     rx_ready_clr_o,
  input  logic                     flush_i,
  output logic [7:0]               out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overrun_o,
  input  logic                     overrun_clr_i,
  output logic [7:0]               drop_cnt_o
);

  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rx_ready_q;
  logic              rx_ready_clr_q;
  logic              overrun_q, overrun_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              push_req;
  logic              pop;
  logic              push;
  logic              drop;
  logic              full;
  logic              empty;

  // Status decodes come from the count register only, so out_valid never
  // depends combinationally on out_ready.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_req = rx_ready_i & ~rx_ready_q;
  assign pop      = ~empty & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);
  // A byte arriving during a flush is discarded silently, not as a drop.
  assign drop     = push_req & full & ~pop & ~flush_i;

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Setting wins over clearing: a drop coincident with overrun_clr
    // leaves the flag set and restarts the counter at one.
    if (drop) begin
      overrun_d = 1'b1;
      if (overrun_clr_i)            drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (overrun_clr_i) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rx_ready_q     <= 1'b0;
      rx_ready_clr_q <= 1'b0;
      overrun_q      <= 1'b0;
      drop_cnt_q     <= 8'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rx_ready_q     <= rx_ready_i;
      rx_ready_clr_q <= push_req;
      overrun_q      <= overrun_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem[wr_ptr_q] <= rx_data_i;
  end

  assign rx_ready_clr_o = rx_ready_clr_q;
  assign out_data_o     = mem[rd_ptr_q];
  assign out_valid_o    = ~empty;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign overrun_o      = overrun_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each completed byte from the receiver's data/ready outputs and returns a one-cycle ready-clear pulse. Stores bytes in a DEPTH-entry first-word-fall-through FIFO and presents them on a valid/ready stream to the consumer (CPU bus bridge or packet parser). Flags and counts bytes lost to overflow.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
rx_data  input  8  byte from receiver; stable while rx_ready high
rx_ready  input  1  receiver byte-available level
rx_ready_clr  output  1  one-cycle pulse to receiver, acknowledges capture
flush  input  1  synchronous FIFO empty request
out_data  output  8  head-of-FIFO byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head byte when high with out_valid
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overrun  output  1  sticky: byte dropped because FIFO full
overrun_clr  input  1  clears overrun and drop_cnt
drop_cnt  output  8  saturating count of dropped bytes

Behaviour:
- Reset (reset_n low at clk edge): pointers, count, rx_ready_q, rx_ready_clr, overrun, drop_cnt all 0; empty=1, full=0, out_valid=0. Storage contents are not reset; out_data is don't-care while out_valid=0. Reset mid-operation discards all stored bytes.
- Capture: rx_ready_q is rx_ready registered. push_req = rx_ready & ~rx_ready_q (rising edge). One push_req per receiver byte, even though rx_ready falls one cycle after the clear.
- rx_ready_clr: registered. High for exactly the one cycle after push_req, whether or not the byte was stored.
- rx_ready high on the first cycle out of reset counts as an edge (rx_ready_q resets to 0).
- Pop: pop = out_valid & out_ready.
- out_data = mem[rd_ptr], combinational from the storage array. Zero-latency fall-through: a byte pushed at edge N is visible with out_valid=1 after edge N.
- Push acceptance: push = push_req & (~full | pop). When full, a simultaneous pop frees the slot and the push is accepted; count stays DEPTH.
- Overflow: push_req & full & ~pop drops the byte. overrun is set and drop_cnt increments, saturating at 255. Pointers and count are unchanged.
- Pointers: ADDR_W bits, wrap modulo DEPTH. wr_ptr advances on push, rd_ptr on pop.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows; pop requires out_valid.
- full and empty are decoded from the count register, so they are valid the cycle after the update.
- flush: pointers and count go to 0 next edge; any same-cycle push and pop are ignored. overrun and drop_cnt are unaffected. A push_req in the flush cycle is lost without counting as a drop, but rx_ready_clr still pulses.
- overrun_clr: clears overrun and drop_cnt next edge. If an overflow occurs in the same cycle, set wins: overrun=1, drop_cnt=1.
- No combinational path from out_ready to out_valid. out_ready affects only next-state logic.

Test Plan:
- Single byte: rx_data=0xA5, rx_ready rises and is held 3 cycles -> exactly one rx_ready_clr pulse, count=1, out_valid=1, out_data=0xA5. Assert out_ready 1 cycle -> empty=1, count=0.
- Fill and wrap: push 0x00..0x0F with out_ready=0 -> full=1, count=16. Pop 8, push 0x10..0x17 -> drained order 0x08..0x17, no overrun.
- Overflow: full FIFO, 3 more bytes, no pops -> 3 clr pulses, overrun=1, drop_cnt=3, contents unchanged. Push 255+ extra -> drop_cnt=255. overrun_clr -> both 0.
- Full with simultaneous push/pop: full FIFO, push_req cycle with out_ready=1 -> byte accepted, count stays 16, overrun stays 0, new byte emerges last.
- Flush and reset mid-op: count=5, flush -> count=0, empty=1, overrun retained. Refill 4, reset_n low 1 cycle -> all outputs at reset values, subsequent byte 0x3C is output first.
- Set-wins: overrun_clr asserted in the same cycle as an overflow push -> overrun=1, drop_cnt=1.
